// File: rtl/bp_me_pkg.sv
// Shared memory-engine helpers: credit counter sizing and credit update encoding.
package bp_me_pkg;

  // Bits needed to hold a credit count from 0 up to max_credits inclusive
  function automatic int unsigned credits_width(input int unsigned max_credits);
    return 32'($clog2(max_credits + 32'd1));
  endfunction

  typedef enum logic [1:0] {
    e_credit_hold   = 2'd0,
    e_credit_spend  = 2'd1,
    e_credit_return = 2'd2
  } credit_op_e;

endpackage

// File: rtl/bp_cce_mem_cmd_issue_if.sv
// Memory command header handshakes: CCE-to-block (in) and block-to-network (out).
interface bp_cce_mem_cmd_issue_if #(
  parameter int unsigned header_width_p = 128
);
  logic [header_width_p-1:0] mem_cmd_header_i;
  logic                      mem_cmd_header_v_i;
  logic                      mem_cmd_header_ready_and_o;
  logic [header_width_p-1:0] mem_cmd_header_o;
  logic                      mem_cmd_header_v_o;
  logic                      mem_cmd_header_ready_and_i;

  modport slave (
    input  mem_cmd_header_i,
    input  mem_cmd_header_v_i,
    output mem_cmd_header_ready_and_o,
    output mem_cmd_header_o,
    output mem_cmd_header_v_o,
    input  mem_cmd_header_ready_and_i
  );

  modport master (
    output mem_cmd_header_i,
    output mem_cmd_header_v_i,
    input  mem_cmd_header_ready_and_o,
    input  mem_cmd_header_o,
    input  mem_cmd_header_v_o,
    output mem_cmd_header_ready_and_i
  );
endinterface

// File: rtl/bp_cce_mem_cmd_fifo2.sv
// Two-entry header FIFO, ready/valid on both sides; outputs depend on registered state only.
module bp_cce_mem_cmd_fifo2 #(
  parameter int unsigned width_p = 128
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [width_p-1:0] i_data,
  input  logic               i_v,
  output logic               o_ready_and,
  output logic [width_p-1:0] o_data,
  output logic               o_v,
  input  logic               i_ready_and
);

  logic [width_p-1:0] r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_count;
  logic               w_enq;
  logic               w_deq;

  assign o_ready_and = (r_count != 2'd2);
  assign o_v         = (r_count != 2'd0);
  assign o_data      = r_mem[r_rptr];
  assign w_enq       = i_v & o_ready_and;
  assign w_deq       = o_v & i_ready_and;

  // Pointers and occupancy; simultaneous enq/deq leaves occupancy unchanged
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; flushed entries are unreachable once pointers clear
  always_ff @(posedge i_clk) begin
    if (w_enq) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/bp_cce_mem_cmd_issue.sv
// CCE memory command issue stage: 2-entry header buffer plus memory network credit tracking.
// Optional sticky credit error flag enabled by `define BP_CCE_MEM_CREDIT_ERROR_EN.
module bp_cce_mem_cmd_issue
  import bp_me_pkg::*;
#(
  parameter  int unsigned mem_noc_max_credits_p = 8,
  parameter  int unsigned header_width_p        = 128,
  localparam int unsigned lg_credits_lp         = credits_width(mem_noc_max_credits_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  bp_cce_mem_cmd_issue_if.slave    ifc,
  input  logic                     mem_resp_yumi_i,
  output logic                     mem_credits_empty_o,
  output logic                     mem_credits_full_o,
  output logic [lg_credits_lp-1:0] credit_count_o,
  output logic                     credit_error_o
);

  localparam logic [lg_credits_lp-1:0] max_credits_lp = lg_credits_lp'(mem_noc_max_credits_p);

  logic                     w_accept;
  credit_op_e               w_op;
  logic [lg_credits_lp-1:0] r_credits;

  bp_cce_mem_cmd_fifo2 #(
    .width_p (header_width_p)
  ) u_fifo (
    .i_clk       (clk_i),
    .i_reset_n   (reset_n_i),
    .i_data      (ifc.mem_cmd_header_i),
    .i_v         (ifc.mem_cmd_header_v_i),
    .o_ready_and (ifc.mem_cmd_header_ready_and_o),
    .o_data      (ifc.mem_cmd_header_o),
    .o_v         (ifc.mem_cmd_header_v_o),
    .i_ready_and (ifc.mem_cmd_header_ready_and_i)
  );

  assign w_accept = ifc.mem_cmd_header_v_i & ifc.mem_cmd_header_ready_and_o;

  // Accept and return in the same cycle cancel out
  always_comb begin
    w_op = e_credit_hold;
    if (w_accept && !mem_resp_yumi_i)      w_op = e_credit_spend;
    else if (mem_resp_yumi_i && !w_accept) w_op = e_credit_return;
  end

  // Saturating credit counter
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_credits <= max_credits_lp;
    end else begin
      case (w_op)
        e_credit_spend:  if (r_credits != '0)             r_credits <= r_credits - lg_credits_lp'(1);
        e_credit_return: if (r_credits != max_credits_lp) r_credits <= r_credits + lg_credits_lp'(1);
        default:         r_credits <= r_credits;
      endcase
    end
  end

  assign credit_count_o      = r_credits;
  assign mem_credits_empty_o = (r_credits == '0);
  assign mem_credits_full_o  = (r_credits == max_credits_lp);

`ifdef BP_CCE_MEM_CREDIT_ERROR_EN
  logic w_underflow;
  logic w_overflow;
  logic r_credit_error;

  assign w_underflow = (w_op == e_credit_spend)  && (r_credits == '0);
  assign w_overflow  = (w_op == e_credit_return) && (r_credits == max_credits_lp);

  // Sticky until reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                     r_credit_error <= 1'b0;
    else if (w_underflow || w_overflow) r_credit_error <= 1'b1;
  end

  assign credit_error_o = r_credit_error;

  a_credit_bounds: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                    !(w_underflow || w_overflow));
`else
  assign credit_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_cce_mem_cmd_issue.sv
// Self-checking bench for bp_cce_mem_cmd_issue: per-cycle reference model with a header scoreboard.
module tb_bp_cce_mem_cmd_issue;

  localparam int unsigned MAXC = 8;
  localparam int unsigned HW   = 128;
`ifdef BP_CCE_MEM_CREDIT_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         yumi;
  logic         credits_empty;
  logic         credits_full;
  logic [3:0]   credit_count;
  logic         credit_error;

  bp_cce_mem_cmd_issue_if #(.header_width_p(HW)) ifc ();

  bp_cce_mem_cmd_issue #(
    .mem_noc_max_credits_p (MAXC),
    .header_width_p        (HW)
  ) dut (
    .clk_i               (clk),
    .reset_n_i           (rst_n),
    .ifc                 (ifc),
    .mem_resp_yumi_i     (yumi),
    .mem_credits_empty_o (credits_empty),
    .mem_credits_full_o  (credits_full),
    .credit_count_o      (credit_count),
    .credit_error_o      (credit_error)
  );

  always #5 clk = ~clk;

  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  logic [HW-1:0] sb_q[$];
  int            m_occ;
  int            m_cred;
  logic          m_err;
  logic          last_acc;

  task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_occ  = 0;
    m_cred = MAXC;
    m_err  = 1'b0;
    sb_q.delete();
  endtask

  task automatic check_outputs();
    check("ready_and_o", HW'(ifc.mem_cmd_header_ready_and_o), HW'(m_occ != 2));
    check("v_o", HW'(ifc.mem_cmd_header_v_o), HW'(m_occ != 0));
    if (m_occ != 0 && sb_q.size() != 0) check("header_o", ifc.mem_cmd_header_o, sb_q[0]);
    check("credit_count", HW'(credit_count), HW'(m_cred));
    check("credits_empty", HW'(credits_empty), HW'(m_cred == 0));
    check("credits_full", HW'(credits_full), HW'(m_cred == MAXC));
    check("credit_error", HW'(credit_error), HW'(m_err));
  endtask

  // One clock: check model state, drive inputs, advance model across the edge
  task automatic step(input logic v, input logic [HW-1:0] hdr, input logic rdy, input logic y);
    logic acc, deq;
    @(negedge clk);
    check_outputs();
    ifc.mem_cmd_header_v_i         = v;
    ifc.mem_cmd_header_i           = hdr;
    ifc.mem_cmd_header_ready_and_i = rdy;
    yumi                           = y;
    acc = v && (m_occ != 2);
    deq = (m_occ != 0) && rdy;
    @(posedge clk);
    #1;
    if (deq) void'(sb_q.pop_front());
    if (acc) sb_q.push_back(hdr);
    m_occ = m_occ + int'(acc) - int'(deq);
    if (acc && !y) begin
      if (m_cred == 0) m_err = m_err | ERR_EN;
      else m_cred--;
    end else if (y && !acc) begin
      if (m_cred == MAXC) m_err = m_err | ERR_EN;
      else m_cred++;
    end
    last_acc = acc;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0);
  endtask

  initial begin
    logic [HW-1:0] abc [3];
    int            idx;
    abc[0] = HW'(32'hA);
    abc[1] = HW'(32'hB);
    abc[2] = HW'(32'hC);

    rst_n                          = 1'b0;
    yumi                           = 1'b0;
    ifc.mem_cmd_header_v_i         = 1'b0;
    ifc.mem_cmd_header_i           = '0;
    ifc.mem_cmd_header_ready_and_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state, idle
    idle(2, 1'b0);

    // 8 back-to-back accepts at full throughput, headers drain in order
    for (int i = 1; i <= 8; i++) step(1'b1, HW'(i), 1'b1, 1'b0);
    idle(2, 1'b1);

    // Underflow: accept at zero credits
    step(1'b1, HW'(32'h99), 1'b1, 1'b0);
    idle(2, 1'b1);

    // Restore all credits, then one extra return overflows
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b1);
    idle(1, 1'b1);

    // Network stalled: two accepted, third held until network ready
    idx = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, abc[idx], 1'b0, 1'b0);
      if (last_acc) idx++;
    end
    for (int k = 0; k < 10 && idx < 3; k++) begin
      step(1'b1, abc[idx], 1'b1, 1'b0);
      if (last_acc) idx++;
    end
    check("abc_all_accepted", HW'(idx), HW'(3));
    idle(4, 1'b1);

    // Count to 3, then accept+return together, then a lone return
    step(1'b1, HW'(32'h20), 1'b1, 1'b0);
    step(1'b1, HW'(32'h21), 1'b1, 1'b0);
    check("count_at_3", HW'(credit_count), HW'(3));
    step(1'b1, HW'(32'h22), 1'b1, 1'b1);
    check("count_hold_3", HW'(credit_count), HW'(3));
    step(1'b0, '0, 1'b1, 1'b1);
    check("count_ret_4", HW'(credit_count), HW'(4));
    idle(3, 1'b1);

    // Build up two buffered entries at count 5, then reset mid-cycle
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, HW'(32'h40), 1'b0, 1'b0);
    step(1'b1, HW'(32'h41), 1'b0, 1'b0);
    check("pre_reset_count", HW'(credit_count), HW'(5));
    check("pre_reset_v", HW'(ifc.mem_cmd_header_v_o), HW'(1));
    #2;
    rst_n                          = 1'b0;
    ifc.mem_cmd_header_v_i         = 1'b0;
    ifc.mem_cmd_header_ready_and_i = 1'b1;
    yumi                           = 1'b0;
    #1;
    check("rst_ready", HW'(ifc.mem_cmd_header_ready_and_o), HW'(1));
    check("rst_v", HW'(ifc.mem_cmd_header_v_o), HW'(0));
    check("rst_count", HW'(credit_count), HW'(MAXC));
    check("rst_full", HW'(credits_full), HW'(1));
    check("rst_empty", HW'(credits_empty), HW'(0));
    check("rst_error", HW'(credit_error), HW'(0));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3, 1'b1);

    // Fresh traffic after reset sees only new headers
    step(1'b1, HW'(32'h55), 1'b1, 1'b0);
    idle(2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
